// File: rtl/dmc_pkg.sv
// Shared types and defaults for the data SRAM controller.
// Optional readback verification of stores is enabled with DMC_WRITE_VERIFY_EN.
package dmc_pkg;
    localparam int DMC_ADDR_W = 21;
    localparam int DMC_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        VSETUP,
        VSTROBE,
        VHOLD,
        RESP
    } dmc_state_e;

    function automatic int dmc_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/dmc_phase_timer.sv
// Loadable down-counter timing one SRAM phase; done while the count is zero.
module dmc_phase_timer
    import dmc_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/data_mem_ctrl.sv
// Single-request controller for the asynchronous data SRAM port (setup/strobe/hold).
// Define DMC_WRITE_VERIFY_EN to read back every store and flag mismatches on rsp_err.
module data_mem_ctrl
    import dmc_pkg::*;
#(
    parameter int ADDR_W     = DMC_ADDR_W,
    parameter int DATA_W     = DMC_DATA_W,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_WE,
    output logic              mem_CS,
    output logic              mem_OE,
    input  logic [DATA_W-1:0] mem_dout
);
    localparam int MAX_PH = dmc_max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W  = $clog2(MAX_PH) + 1;

    dmc_state_e        r_state, w_state_nxt;
    logic              w_accept, w_done, w_load, w_we_nxt;
    logic              w_cs_nxt, w_mem_we_nxt, w_oe_nxt;
    logic [CNT_W-1:0]  w_load_val;
    logic              r_we, r_mem_we, r_mem_cs, r_mem_oe, r_rsp_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;

    assign w_accept = (r_state == IDLE) && req_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = SETUP;
            SETUP:   if (w_done) w_state_nxt = STROBE;
            STROBE:  if (w_done) w_state_nxt = HOLD;
`ifdef DMC_WRITE_VERIFY_EN
            HOLD:    if (w_done) w_state_nxt = r_we ? VSETUP : RESP;
            VSETUP:  if (w_done) w_state_nxt = VSTROBE;
            VSTROBE: if (w_done) w_state_nxt = VHOLD;
            VHOLD:   if (w_done) w_state_nxt = RESP;
`else
            HOLD:    if (w_done) w_state_nxt = RESP;
`endif
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Each phase counter is primed with N-1 on the edge that enters the phase.
    always_comb begin
        w_load_val = '0;
        case (w_state_nxt)
            SETUP, VSETUP:   w_load_val = CNT_W'(SETUP_CYC - 1);
            STROBE, VSTROBE: w_load_val = CNT_W'(STROBE_CYC - 1);
            HOLD, VHOLD:     w_load_val = CNT_W'(HOLD_CYC - 1);
            default:         w_load_val = '0;
        endcase
    end

    assign w_load = (w_state_nxt != r_state);

    dmc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Strobes are registered from the next state so the SRAM pins never glitch.
    assign w_we_nxt     = w_accept ? req_we : r_we;
    assign w_cs_nxt     = (w_state_nxt != IDLE) && (w_state_nxt != RESP);
    assign w_mem_we_nxt = (w_state_nxt == STROBE) && w_we_nxt;
    assign w_oe_nxt     = ((w_state_nxt == STROBE) && !w_we_nxt) || (w_state_nxt == VSTROBE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_cs    <= w_cs_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_oe    <= w_oe_nxt;
            r_rsp_valid <= (w_state_nxt == RESP);
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

`ifdef DMC_WRITE_VERIFY_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if ((r_state == STROBE) && w_done && !r_we) begin
            r_rdata <= mem_dout;
            r_err   <= 1'b0;
        end else if ((r_state == VSTROBE) && w_done) begin
            r_rdata <= mem_dout;
            r_err   <= (mem_dout != r_wdata);
        end
    end

    assign rsp_err = r_err;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if ((r_state == STROBE) && w_done) begin
            r_rdata <= r_we ? '0 : mem_dout;
        end
    end

    assign rsp_err = 1'b0;
`endif

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign mem_address = r_addr;
    assign mem_din     = r_wdata;
    assign mem_WE      = r_mem_we;
    assign mem_CS      = r_mem_cs;
    assign mem_OE      = r_mem_oe;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a small SRAM model; honours DMC_WRITE_VERIFY_EN.
module tb_data_mem_ctrl;
    localparam int AW = 21;
    localparam int DW = 16;
    localparam int S  = 1;
    localparam int ST = 2;
    localparam int H  = 1;
`ifdef DMC_WRITE_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic          clk, reset;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_din, mem_dout;
    logic          mem_WE, mem_CS, mem_OE;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_err = 0;
    int rsp_cnt = 0;

    data_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_din(mem_din),
        .mem_WE(mem_WE), .mem_CS(mem_CS), .mem_OE(mem_OE), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model; with verify enabled, bit0 of every cell is stuck at 0.
    logic [DW-1:0] sram [0:63];
    initial for (int i = 0; i < 64; i++) sram[i] = '0;
    always @(posedge clk)
        if (mem_CS && mem_WE) sram[mem_address[5:0]] <= VER ? (mem_din & 16'hFFFE) : mem_din;
    assign mem_dout = (mem_CS && mem_OE) ? sram[mem_address[5:0]] : '0;

    // Protocol monitor: no WE/OE overlap, no address movement around WE.
    logic          prev_rst = 1'b0;
    logic          prev_we  = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (reset && prev_rst) begin
            if (mem_WE && mem_OE) mon_err++;
            if ((mem_WE || prev_we) && (mem_address != prev_addr)) mon_err++;
        end
        if (rsp_valid) rsp_cnt++;
        prev_rst  = reset;
        prev_we   = mem_WE;
        prev_addr = mem_address;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [DW-1:0] stick(input logic [DW-1:0] x);
        return VER ? (x & 16'hFFFE) : x;
    endfunction

    function automatic vec_t mk_store(input logic [AW-1:0] a, input logic [DW-1:0] w);
        vec_t v;
        v.we = 1'b1; v.addr = a; v.wdata = w;
        v.exp_rdata = VER ? stick(w) : '0;
        v.exp_err   = VER ? (stick(w) != w) : 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        vec_t v;
        v.we = 1'b0; v.addr = a; v.wdata = '0; v.exp_rdata = d; v.exp_err = 1'b0;
        return v;
    endfunction

    function automatic int latency(input logic we);
        return S + ST + H + 1 + ((VER && we) ? (S + ST + H) : 0);
    endfunction

    // Expected {CS, WE, OE, rsp_valid} k cycles after the accept cycle.
    function automatic logic [3:0] exp_sig(input int k, input logic we, input int lat);
        int p;
        logic cs, wev, oe, rv;
        cs = 0; wev = 0; oe = 0; rv = 0; p = k;
        if (k == lat) rv = 1;
        else begin
            cs = 1;
            if (p > S + ST + H) begin
                p = p - (S + ST + H);
                if (p > S && p <= S + ST) oe = 1;
            end else if (p > S && p <= S + ST) begin
                if (we) wev = 1; else oe = 1;
            end
        end
        return {cs, wev, oe, rv};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check(name, req_ready, 1);
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int lat;
        lat = latency(v.we);
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        wait_ready($sformatf("v%0d_ready", idx));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            check($sformatf("v%0d_sig_k%0d", idx, k), {mem_CS, mem_WE, mem_OE, rsp_valid},
                  exp_sig(k, v.we, lat));
            if (k < lat) check($sformatf("v%0d_addr_k%0d", idx, k), mem_address, v.addr);
        end
        check($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), rsp_err, v.exp_err);
        @(negedge clk);
        check($sformatf("v%0d_idle", idx), {req_ready, rsp_valid, mem_CS}, 3'b100);
    endtask

    initial begin
        int acc_cyc [3];
        logic acc_we [3];
        int n_acc, cyc, rsp0;
        bit flip;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset held with random request traffic.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom); req_we = 1'($urandom);
            req_addr = AW'($urandom); req_wdata = DW'($urandom);
            #1;
            check($sformatf("rst_ctl_%0d", i), {mem_WE, mem_CS, mem_OE, req_ready, rsp_valid}, 5'b00010);
        end
        check("rst_data", {mem_address, mem_din, rsp_rdata, rsp_err}, '0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;

        vecs[0] = mk_store(21'h00010, 16'hA5A5);
        vecs[1] = mk_load (21'h00010, stick(16'hA5A5));
        vecs[2] = mk_store(21'h1FFFFF, 16'h5A5A);
        vecs[3] = mk_load (21'h1FFFFF, stick(16'h5A5A));
        vecs[4] = mk_store(21'h00000, 16'hFFFF);
        vecs[5] = mk_load (21'h00000, stick(16'hFFFF));
        vecs[6] = mk_store(21'h00030, 16'h0001);
        vecs[7] = mk_load (21'h00030, stick(16'h0001));
        vecs[8] = mk_load (21'h00010, stick(16'hA5A5));
        for (int i = 0; i < 9; i++) do_txn(vecs[i], i);

        // Request held continuously, alternating load/store after each accept.
        rsp0 = rsp_cnt; n_acc = 0; cyc = 0; flip = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 21'h00010; req_wdata = 16'h3C3C;
        while (n_acc < 3 && cyc < 60) begin
            if (req_ready) begin
                acc_cyc[n_acc] = cyc; acc_we[n_acc] = req_we; n_acc++; flip = 1;
            end
            @(negedge clk);
            cyc++;
            if (flip) begin
                req_we = ~req_we; req_addr = req_addr + 1'b1; flip = 0;
            end
        end
        req_valid = 1'b0;
        check("hold_accepts", n_acc, 3);
        if (n_acc == 3) begin
            check("hold_space1", acc_cyc[1] - acc_cyc[0], latency(acc_we[0]) + 1);
            check("hold_space2", acc_cyc[2] - acc_cyc[1], latency(acc_we[1]) + 1);
        end
        repeat (12) @(negedge clk);
        check("hold_rsp_count", rsp_cnt - rsp0, 3);

        // Reset dropped while a store is strobing.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 21'h00020; req_wdata = 16'h1234;
        wait_ready("rst_mid_ready");
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_we_before", {mem_CS, mem_WE}, 2'b11);
        #2 reset = 1'b0;
        #1 check("rst_mid_async", {mem_CS, mem_WE, mem_OE, req_ready}, 4'b0001);
        rsp0 = rsp_cnt;
        repeat (8) @(negedge clk);
        check("rst_mid_no_rsp", rsp_cnt - rsp0, 0);
        reset = 1'b1;
        do_txn(mk_load(21'h00010, stick(16'hA5A5)), 9);

        check("monitor", mon_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
